// File: rtl/eth_fcs_checker_if.sv
// Byte-stream bundle around the Ethernet FCS checker: received bytes in,
// FCS-stripped payload and per-frame status out.
interface eth_fcs_checker_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_last;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        done;
    logic        fcs_ok;
    logic        len_err;
    logic [10:0] frame_len;
    logic [31:0] crc_out;

    // master drives received bytes and consumes the checker's results
    modport master (
        output rx_data, rx_valid, rx_last,
        input  out_data, out_valid, out_last, done, fcs_ok, len_err, frame_len, crc_out
    );

    modport slave (
        input  rx_data, rx_valid, rx_last,
        output out_data, out_valid, out_last, done, fcs_ok, len_err, frame_len, crc_out
    );
endinterface

// File: rtl/eth_fcs_checker.sv
// Receive-side Ethernet FCS checker: folds every byte (FCS included) into a
// reflected CRC-32, forwards payload through a 4-byte delay line, reports status per frame.
module eth_fcs_checker #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic              clk,
    input  logic              reset,
    eth_fcs_checker_if.slave  bus
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] CNT_MAX     = 11'h7FF;
    localparam logic [10:0] MIN_LEN_C   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_C   = 11'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RX,
        S_REPORT
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_crc;
    logic [10:0] r_count;
    logic [7:0]  r_dly [0:3];
    logic [2:0]  r_fill;

    logic [7:0]  r_out_data;
    logic        r_out_valid;
    logic        r_out_last;
    logic        r_done;
    logic        r_fcs_ok;
    logic        r_len_err;
    logic [10:0] r_frame_len;
    logic [31:0] r_crc_out;

    logic        w_beat;
    logic        w_end;
    logic        w_start;
    logic [31:0] w_crc_base;
    logic [31:0] w_crc_next;
    logic [10:0] w_count_next;
    logic        w_len_err;
    logic        w_fcs_ok;
    logic [8:0][31:0] w_crc_stage;

    assign w_beat  = bus.rx_valid;
    assign w_end   = bus.rx_valid & bus.rx_last;
    // Any beat outside RX opens a new frame, including one landing in the REPORT cycle
    assign w_start = w_beat && (r_state != S_RX);

    assign w_crc_base     = w_start ? CRC_INIT : r_crc;
    assign w_crc_stage[0] = w_crc_base;

    // Bit-serial reflected CRC unrolled over the byte, LSB first
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
            assign w_crc_stage[gi+1] = (w_crc_stage[gi][0] ^ bus.rx_data[gi])
                                     ? ((w_crc_stage[gi] >> 1) ^ CRC_POLY)
                                     : (w_crc_stage[gi] >> 1);
        end
    endgenerate

    assign w_crc_next   = w_crc_stage[8];
    assign w_count_next = w_start ? 11'd1
                        : ((r_count == CNT_MAX) ? r_count : r_count + 11'd1);
    assign w_len_err    = (w_count_next < MIN_LEN_C) || (w_count_next > MAX_LEN_C);
    assign w_fcs_ok     = (w_crc_next == CRC_RESIDUE) && !w_len_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_REPORT: begin
                if (w_end) begin
                    w_state_next = S_REPORT;
                end else if (w_beat) begin
                    w_state_next = S_RX;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RX: begin
                if (w_end) begin
                    w_state_next = S_REPORT;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc       <= CRC_INIT;
            r_count     <= '0;
            r_fill      <= '0;
            for (int i = 0; i < 4; i++) begin
                r_dly[i] <= '0;
            end
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_fcs_ok    <= 1'b0;
            r_len_err   <= 1'b0;
            r_frame_len <= '0;
            r_crc_out   <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            if (w_beat) begin
                r_crc   <= w_crc_next;
                r_count <= w_count_next;
                // A full line means the oldest byte is now known not to be FCS
                if (r_fill == 3'd4) begin
                    r_out_data  <= r_dly[0];
                    r_out_valid <= 1'b1;
                    r_out_last  <= bus.rx_last;
                    r_dly[0]    <= r_dly[1];
                    r_dly[1]    <= r_dly[2];
                    r_dly[2]    <= r_dly[3];
                    r_dly[3]    <= bus.rx_data;
                end else begin
                    r_dly[r_fill[1:0]] <= bus.rx_data;
                    r_fill             <= r_fill + 3'd1;
                end
                // Closing beat: the four held bytes are the FCS and are dropped
                if (w_end) begin
                    r_fill      <= '0;
                    r_done      <= 1'b1;
                    r_fcs_ok    <= w_fcs_ok;
                    r_len_err   <= w_len_err;
                    r_frame_len <= w_count_next;
                    r_crc_out   <= w_crc_next;
                end
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.done      = r_done;
    assign bus.fcs_ok    = r_fcs_ok;
    assign bus.len_err   = r_len_err;
    assign bus.frame_len = r_frame_len;
    assign bus.crc_out   = r_crc_out;

endmodule

// File: tb/tb_eth_fcs_checker.sv
// Scoreboard bench for eth_fcs_checker: directed frames plus random frames,
// expectations derived from a frame-level CRC/length model.
module tb_eth_fcs_checker;

    localparam int MIN_LEN = 5;
    localparam int MAX_LEN = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    eth_fcs_checker_if bus ();

    eth_fcs_checker #(
        .MIN_LEN(MIN_LEN),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } pay_t;

    typedef struct packed {
        logic        fcs_ok;
        logic        len_err;
        logic [10:0] len;
        logic [31:0] crc;
    } stat_t;

    pay_t       exp_pay[$];
    stat_t      exp_stat[$];
    logic [7:0] frame_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // CRC register (no final inversion) after the first n bytes of frame_q
    function automatic logic [31:0] crc_over(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, frame_q[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return c;
    endfunction

    task automatic push_expect();
        int    n;
        stat_t s;
        n = frame_q.size();
        for (int i = 0; i < n - 4; i++) begin
            exp_pay.push_back('{last: (i == n - 5), data: frame_q[i]});
        end
        s.len     = (n > 2047) ? 11'd2047 : 11'(n);
        s.len_err = (int'(s.len) < MIN_LEN) || (int'(s.len) > MAX_LEN);
        s.crc     = crc_over(n);
        s.fcs_ok  = (s.crc == 32'hDEBB20E3) && !s.len_err;
        exp_stat.push_back(s);
    endtask

    task automatic drive(input int count, input int gmin, input int gmax);
        int g;
        for (int i = 0; i < count; i++) begin
            bus.rx_data  = frame_q[i];
            bus.rx_valid = 1'b1;
            bus.rx_last  = (i == frame_q.size() - 1);
            @(negedge clk);
            if (i < count - 1) begin
                g = int'($urandom_range(gmax, gmin));
                for (int j = 0; j < g; j++) begin
                    bus.rx_valid = 1'b0;
                    bus.rx_last  = 1'($urandom % 2);
                    bus.rx_data  = 8'($urandom);
                    @(negedge clk);
                end
            end
        end
        bus.rx_valid = 1'b0;
        bus.rx_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        bus.rx_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int gmin, input int gmax);
        push_expect();
        drive(frame_q.size(), gmin, gmax);
    endtask

    task automatic load_t1();
        frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                    8'h26, 8'h39, 8'hF4, 8'hCB};
    endtask

    task automatic make_random(input int n, input bit good);
        logic [31:0] fcs;
        frame_q.delete();
        if (good && n >= 4) begin
            for (int i = 0; i < n - 4; i++) frame_q.push_back(8'($urandom));
            fcs = ~crc_over(n - 4);
            for (int b = 0; b < 4; b++) frame_q.push_back(fcs[8*b +: 8]);
        end else begin
            for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents payload or status
    always @(negedge clk) begin
        pay_t  p;
        stat_t s;
        if (!reset) begin
            if (bus.out_valid) begin
                if (exp_pay.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_payload: got 0x%02h, expected no output", bus.out_data);
                end else begin
                    p = exp_pay.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(p.data));
                    check("out_last", 32'(bus.out_last), 32'(p.last));
                end
            end else if (bus.out_last) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_out_last: got 1, expected 0 without out_valid");
            end
            if (bus.done) begin
                if (exp_stat.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done, expected none");
                end else begin
                    s = exp_stat.pop_front();
                    check("fcs_ok", 32'(bus.fcs_ok), 32'(s.fcs_ok));
                    check("len_err", 32'(bus.len_err), 32'(s.len_err));
                    check("frame_len", 32'(bus.frame_len), 32'(s.len));
                    check("crc_out", bus.crc_out, s.crc);
                end
                n_frames++;
                $display("frame %0d: len=%0d fcs_ok=%0b len_err=%0b crc=%08h",
                         n_frames, bus.frame_len, bus.fcs_ok, bus.len_err, bus.crc_out);
            end
        end
    end

    initial begin
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.rx_last  = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_fcs_ok", 32'(bus.fcs_ok), 32'd0);
        check("rst_len_err", 32'(bus.len_err), 32'd0);
        check("rst_frame_len", 32'(bus.frame_len), 32'd0);
        check("rst_crc_out", bus.crc_out, 32'd0);

        // Good frame, corrupted frame, gapped frame, runt
        load_t1(); send_frame(0, 0); idle(3);
        load_t1(); frame_q[4] = 8'h36; send_frame(0, 0); idle(3);
        load_t1(); send_frame(3, 3); idle(3);
        frame_q = '{8'h26, 8'h39, 8'hF4, 8'hCB}; send_frame(0, 0); idle(3);

        // Back-to-back: second frame starts in the REPORT cycle
        load_t1(); send_frame(0, 0);
        load_t1(); frame_q[4] = 8'h36; send_frame(0, 0); idle(3);

        // Reset after 6 bytes: only the first two payload bytes have emerged
        load_t1();
        exp_pay.push_back('{last: 1'b0, data: 8'h31});
        exp_pay.push_back('{last: 1'b0, data: 8'h32});
        drive(6, 0, 0);
        idle(1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load_t1(); send_frame(0, 0); idle(3);

        // Single-byte frames, including one opened in a REPORT cycle
        frame_q = '{8'hA5}; send_frame(0, 0);
        frame_q = '{8'h5A}; send_frame(0, 0); idle(2);

        for (int f = 0; f < 40; f++) begin
            make_random(int'($urandom_range(40, 1)), ($urandom % 4) != 0);
            send_frame(0, ($urandom % 2) ? 0 : 2);
            if (($urandom % 3) != 0) idle(int'($urandom_range(3, 1)));
        end
        idle(2);

        // Oversized frame drives the byte counter into saturation
        make_random(2100, 1'b1); send_frame(0, 0); idle(3);

        for (int i = 0; i < 20 && (exp_pay.size() != 0 || exp_stat.size() != 0); i++) begin
            @(negedge clk);
        end
        check("drain_payload", 32'(exp_pay.size()), 32'd0);
        check("drain_status", 32'(exp_stat.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
